// File: rtl/lift_pkg.sv
// rtl/lift_pkg.sv - shared constants, state encoding and request-scan helpers for the lift car
package lift_pkg;

    localparam int NUM_FLOORS        = 11;
    localparam int FLOOR_W           = 4;
    localparam int TRAVEL_CYCLES_DEF = 8;
    localparam int DOOR_CYCLES_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_t;

    // One-hot mask for a floor index.
    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] flr);
        return NUM_FLOORS'(1) << flr;
    endfunction

    // True when any request sits strictly above flr.
    function automatic logic any_above(input logic [NUM_FLOORS-1:0] pend,
                                       input logic [FLOOR_W-1:0]    flr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(flr) && pend[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // True when any request sits strictly below flr.
    function automatic logic any_below(input logic [NUM_FLOORS-1:0] pend,
                                       input logic [FLOOR_W-1:0]    flr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(flr) && pend[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/lift_car_controller_if.sv
// rtl/lift_car_controller_if.sv - dispatcher/cab request inputs and car status outputs
interface lift_car_if;
    import lift_pkg::*;

    logic [NUM_FLOORS-1:0] assign_req;
    logic [NUM_FLOORS-1:0] cab_req;
    logic [FLOOR_W-1:0]    liftstate;
    logic [NUM_FLOORS-1:0] pending;
    logic [NUM_FLOORS-1:0] served;
    logic                  moving;
    logic                  dir_up;
    logic                  door_open;

    // Dispatcher / cab side: drives requests, observes car status.
    modport master (
        output assign_req, cab_req,
        input  liftstate, pending, served, moving, dir_up, door_open
    );

    // Car controller side.
    modport slave (
        input  assign_req, cab_req,
        output liftstate, pending, served, moving, dir_up, door_open
    );

endinterface

// File: rtl/lift_timer.sv
// rtl/lift_timer.sv - loadable down-counter with zero flag, shared by travel and door timing
module lift_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over counting; the counter parks at zero rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/lift_car_controller.sv
// rtl/lift_car_controller.sv - per-car SCAN sequencer: pending stops, floor stepping, door timing
module lift_car_controller
    import lift_pkg::*;
#(
    parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
    parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    lift_car_if.slave  bus
);

    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W    = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    state_t                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] served_q, served_d;
    logic                  dir_up_q, dir_up_d;

    logic [NUM_FLOORS-1:0] req_in;
    logic [NUM_FLOORS-1:0] pend_all;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [NUM_FLOORS-1:0] cur_bit;
    logic [NUM_FLOORS-1:0] step_bit;
    logic [FLOOR_W-1:0]    step_floor;
    logic                  timer_load;
    logic [TIMER_W-1:0]    timer_value;
    logic                  timer_zero;

    assign req_in   = bus.assign_req | bus.cab_req;
    assign pend_all = pending_q | req_in;
    assign cur_bit  = floor_bit(floor_q);
    assign step_bit = floor_bit(step_floor);

    lift_timer #(.W(TIMER_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // Neighbouring floor in the travel direction, pinned at the shaft ends.
    always_comb begin
        step_floor = floor_q;
        if (dir_up_q) begin
            if (floor_q != TOP_FLOOR) begin
                step_floor = floor_q + 1'b1;
            end
        end else begin
            if (floor_q != '0) begin
                step_floor = floor_q - 1'b1;
            end
        end
    end

    // Sequencer: decides stops, direction and timer reloads; a cleared bit is the floor served now.
    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        dir_up_d    = dir_up_q;
        clear_mask  = '0;
        served_d    = '0;
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_q)
            IDLE: begin
                if ((pending_q & cur_bit) != '0) begin
                    clear_mask  = cur_bit;
                    served_d    = cur_bit;
                    state_d     = DOOR_OPEN;
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (pending_q != '0) begin
                    // Keep sweeping while work lies ahead; otherwise turn round.
                    if (dir_up_q ? !any_above(pending_q, floor_q)
                                 : !any_below(pending_q, floor_q)) begin
                        dir_up_d = !dir_up_q;
                    end
                    state_d     = MOVING;
                    timer_load  = 1'b1;
                    timer_value = TRAVEL_LOAD;
                end
            end
            MOVING: begin
                if (timer_zero) begin
                    floor_d = step_floor;
                    // Same-cycle requests for the arrival floor still stop the car.
                    if ((pend_all & step_bit) != '0) begin
                        clear_mask  = step_bit;
                        served_d    = step_bit;
                        state_d     = DOOR_OPEN;
                        timer_load  = 1'b1;
                        timer_value = DOOR_LOAD;
                    end else if (dir_up_q ? any_above(pend_all, step_floor)
                                          : any_below(pend_all, step_floor)) begin
                        timer_load  = 1'b1;
                        timer_value = TRAVEL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                // A call for this floor while open is served on the spot and holds the door.
                if ((req_in & cur_bit) != '0) begin
                    clear_mask  = cur_bit;
                    served_d    = cur_bit;
                    timer_load  = 1'b1;
                    timer_value = DOOR_LOAD;
                end else if (timer_zero) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pending stops: accumulate every request, drop the floor being served.
    always_comb begin
        pending_d = (pending_q | req_in) & ~clear_mask;
    end

    // Car state registers; reset abandons all outstanding work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            floor_q   <= '0;
            pending_q <= '0;
            served_q  <= '0;
            dir_up_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            dir_up_q  <= dir_up_d;
        end
    end

    assign bus.liftstate = floor_q;
    assign bus.pending   = pending_q;
    assign bus.served    = served_q;
    assign bus.moving    = (state_q == MOVING);
    assign bus.dir_up    = dir_up_q;
    assign bus.door_open = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_lift_car_controller.sv
// tb/tb_lift_car_controller.sv - scoreboard bench for the lift car controller
module tb_lift_car_controller;
    import lift_pkg::*;

    typedef struct {
        int                    at;
        logic [NUM_FLOORS-1:0] bits;
        int                    flr;
        logic                  dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   r;
    logic saw_moving;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    lift_car_if bus ();

    lift_car_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic expect_serve(input int at, input int flr, input logic dir);
        exp_t e;
        e.at   = at;
        e.bits = NUM_FLOORS'(1) << flr;
        e.flr  = flr;
        e.dir  = dir;
        sb.push_back(e);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic req(input logic [NUM_FLOORS-1:0] a, input logic [NUM_FLOORS-1:0] c);
        bus.assign_req = a;
        bus.cab_req    = c;
        @(negedge clk);
        bus.assign_req = '0;
        bus.cab_req    = '0;
    endtask

    task automatic wait_idle(input int after);
        int n;
        n = 0;
        while (!(cyc > after && !bus.moving && !bus.door_open && bus.pending == '0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", int'(n < 3000), 1);
    endtask

    // Monitor: every served pulse must match the next expected stop.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.served != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL served_unexpected: got %0h expected none (cycle %0d)", bus.served, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("served_bits",  int'(bus.served),    int'(mon_e.bits));
                check("served_cycle", cyc,                 mon_e.at);
                check("served_floor", int'(bus.liftstate), mon_e.flr);
                check("served_dir",   int'(bus.dir_up),    int'(mon_e.dir));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        bus.assign_req = '0;
        bus.cab_req    = '0;
        repeat (3) @(negedge clk);
        check("rst_liftstate", int'(bus.liftstate), 0);
        check("rst_pending",   int'(bus.pending),   0);
        check("rst_served",    int'(bus.served),    0);
        check("rst_moving",    int'(bus.moving),    0);
        check("rst_dir_up",    int'(bus.dir_up),    1);
        check("rst_door",      int'(bus.door_open), 0);
        rst = 1'b1;
        @(negedge clk);

        // Floor 0 -> 2 on a dispatcher pulse.
        r = cyc;
        expect_serve(r + 18, 2, 1'b1);
        req(11'b000_0000_0100, '0);
        check("s1_pending",  int'(bus.pending), 4);
        check("s1_not_yet_moving", int'(bus.moving), 0);
        at_cyc(r + 2);  check("s1_moving",    int'(bus.moving),    1);
        at_cyc(r + 9);  check("s1_floor0",    int'(bus.liftstate), 0);
        at_cyc(r + 10); check("s1_floor1",    int'(bus.liftstate), 1);
        at_cyc(r + 17); check("s1_floor1b",   int'(bus.liftstate), 1);
        at_cyc(r + 18); check("s1_floor2",    int'(bus.liftstate), 2);
        check("s1_door_open", int'(bus.door_open), 1);
        check("s1_stopped",   int'(bus.moving),    0);
        at_cyc(r + 33); check("s1_door_last", int'(bus.door_open), 1);
        at_cyc(r + 34); check("s1_door_shut", int'(bus.door_open), 0);
        check("s1_pending_clr", int'(bus.pending), 0);
        wait_idle(r + 18);

        // Travel to 5, then a cab call at the current floor.
        r = cyc;
        expect_serve(r + 26, 5, 1'b1);
        req('0, 11'b000_0010_0000);
        wait_idle(r + 26);
        r = cyc;
        expect_serve(r + 2, 5, 1'b1);
        saw_moving = 1'b0;
        req('0, 11'b000_0010_0000);
        check("s2_door_early", int'(bus.door_open), 0);
        at_cyc(r + 2);
        check("s2_door",  int'(bus.door_open), 1);
        check("s2_floor", int'(bus.liftstate), 5);
        while (cyc < r + 20) begin
            if (bus.moving) saw_moving = 1'b1;
            @(negedge clk);
        end
        check("s2_never_moved", int'(saw_moving), 0);
        wait_idle(r + 2);

        // Down to 2, then sweep up to 8 with calls for 4 and 1 arriving mid-travel.
        r = cyc;
        expect_serve(r + 26, 2, 1'b0);
        req('0, 11'b000_0000_0100);
        wait_idle(r + 26);
        r = cyc;
        expect_serve(r + 18,  4, 1'b1);
        expect_serve(r + 67,  8, 1'b1);
        expect_serve(r + 140, 1, 1'b0);
        req('0, 11'b001_0000_0000);
        at_cyc(r + 5);
        req('0, 11'b000_0001_0010);
        check("s3_pending", int'(bus.pending), 11'b001_0001_0010);
        at_cyc(r + 83); check("s3_dir_before", int'(bus.dir_up), 1);
        at_cyc(r + 84); check("s3_dir_after",  int'(bus.dir_up), 0);
        check("s3_reverse_moving", int'(bus.moving), 1);
        wait_idle(r + 140);

        // Door open at 3, same-floor call with two cycles left re-arms the door.
        r = cyc;
        expect_serve(r + 18, 3, 1'b1);
        expect_serve(r + 32, 3, 1'b1);
        req('0, 11'b000_0000_1000);
        at_cyc(r + 31);
        req(11'b000_0000_1000, '0);
        check("s4_pending_absorbed", int'(bus.pending), 0);
        check("s4_door_held", int'(bus.door_open), 1);
        at_cyc(r + 47); check("s4_door_last", int'(bus.door_open), 1);
        at_cyc(r + 48); check("s4_door_shut", int'(bus.door_open), 0);
        wait_idle(r + 32);

        // Top floor: travel to 10, then a call there from both sources.
        r = cyc;
        expect_serve(r + 58, 10, 1'b1);
        req('0, 11'b100_0000_0000);
        wait_idle(r + 58);
        r = cyc;
        expect_serve(r + 2, 10, 1'b1);
        req(11'b100_0000_0000, 11'b100_0000_0000);
        at_cyc(r + 2);  check("s5_floor_top",  int'(bus.liftstate), 10);
        at_cyc(r + 20); check("s5_floor_hold", int'(bus.liftstate), 10);
        check("s5_not_moving", int'(bus.moving), 0);
        wait_idle(r + 2);

        // Reset while climbing from 4 toward 5.
        r = cyc;
        expect_serve(r + 50, 4, 1'b0);
        req('0, 11'b000_0001_0000);
        wait_idle(r + 50);
        r = cyc;
        req('0, 11'b010_1000_0000);
        at_cyc(r + 5);
        check("s6_moving_pre",  int'(bus.moving),    1);
        check("s6_floor_pre",   int'(bus.liftstate), 4);
        rst = 1'b0;
        #1;
        check("s6_rst_floor",   int'(bus.liftstate), 0);
        check("s6_rst_pending", int'(bus.pending),   0);
        check("s6_rst_moving",  int'(bus.moving),    0);
        check("s6_rst_door",    int'(bus.door_open), 0);
        check("s6_rst_dir",     int'(bus.dir_up),    1);
        check("s6_rst_served",  int'(bus.served),    0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("s6_idle_moving",  int'(bus.moving),    0);
        check("s6_idle_floor",   int'(bus.liftstate), 0);
        check("s6_idle_pending", int'(bus.pending),   0);
        check("s6_idle_door",    int'(bus.door_open), 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
